// File: rtl/window_avg_pkg.sv
// Shared helpers for the sliding-window averager: width derivation and
// sign/zero extension and shifting on a wide scratch type.
package window_avg_pkg;

    localparam int MAX_W      = 512;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 8;

    typedef logic [MAX_W-1:0] wide_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Sum width: one extra bit per doubling of the window keeps it exact.
    function automatic int sum_w(input int data_w, input int depth);
        return data_w + clog2(depth);
    endfunction

    localparam int AW_DEF = clog2(DEPTH_DEF);
    localparam int SW_DEF = sum_w(DATA_W_DEF, DEPTH_DEF);

    // Replace every bit at or above position w with the sign bit (sgn=1) or zero.
    function automatic wide_t ext(input wide_t v, input int w, input bit sgn);
        wide_t r;
        r = v;
        for (int i = 0; i < MAX_W; i++) begin
            if (i >= w) r[i] = sgn ? v[w-1] : 1'b0;
        end
        return r;
    endfunction

    function automatic wide_t shr(input wide_t v, input int w, input int sh, input bit sgn);
        return ext(v, w, sgn) >> sh;
    endfunction

endpackage

// File: rtl/window_buf.sv
// Circular register buffer holding the last DEPTH samples; dout_old is the
// entry about to be overwritten at the current write pointer.
module window_buf
    import window_avg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout_old
);

    localparam int AW = clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wp;

    // Zeroed entries make eviction during warm-up subtract nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            wp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[wp] <= din;
            wp      <= wp + AW'(1);
        end
    end

    assign dout_old = mem[wp];

endmodule

// File: rtl/window_avg.sv
// Sliding-window averager: exact running sum over the last DEPTH samples and
// its average. Define WINDOW_AVG_ROUND_EN for round-half-up averaging.
module window_avg
    import window_avg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int SIGNED = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic                               clr,
    input  logic [DATA_W-1:0]                  x,
    output logic [DATA_W-1:0]                  y,
    output logic [DATA_W+clog2(DEPTH)-1:0]     sum,
    output logic                               y_valid
);

    localparam int AW  = clog2(DEPTH);
    localparam int SW  = sum_w(DATA_W, DEPTH);
    localparam bit SGN = (SIGNED != 0);

    logic [DATA_W-1:0] old;
    logic [SW-1:0]     sum_next;
    logic [DATA_W-1:0] avg_next;
    logic [AW:0]       cnt;
    logic [AW+1:0]     cnt_inc;
    wide_t             x_ext;
    wide_t             old_ext;
    wide_t             sum_next_w;

`ifdef WINDOW_AVG_ROUND_EN
    // SW+1-bit add of half an LSB, then clamp in case the shift overflows DATA_W.
    function automatic logic [DATA_W-1:0] calc_avg(input logic [SW-1:0] s);
        wide_t             t;
        wide_t             q;
        logic [DATA_W-1:0] r;
        t = ext(wide_t'(s), SW, SGN) + (wide_t'(1) << (AW-1));
        q = shr(t, SW+1, AW, SGN);
        r = q[DATA_W-1:0];
        if (!SGN && q[DATA_W])
            r = '1;
        else if (SGN && (q[DATA_W] != q[DATA_W-1]))
            r = q[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        return r;
    endfunction
`else
    function automatic logic [DATA_W-1:0] calc_avg(input logic [SW-1:0] s);
        wide_t t;
        t = shr(wide_t'(s), SW, AW, SGN);
        return t[DATA_W-1:0];
    endfunction
`endif

    window_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .we       (en & ~clr),
        .din      (x),
        .dout_old (old)
    );

    always_comb begin
        x_ext      = ext(wide_t'(x), DATA_W, SGN);
        old_ext    = ext(wide_t'(old), DATA_W, SGN);
        sum_next_w = wide_t'(sum) + x_ext - old_ext;
        sum_next   = sum_next_w[SW-1:0];
        avg_next   = calc_avg(sum_next);
        cnt_inc    = {1'b0, cnt} + (AW+2)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            cnt     <= '0;
        end else if (clr) begin
            sum     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            cnt     <= '0;
        end else if (en) begin
            sum     <= sum_next;
            y       <= avg_next;
            y_valid <= (cnt_inc >= (AW+2)'(DEPTH));
            if (cnt_inc <= (AW+2)'(DEPTH)) cnt <= cnt_inc[AW:0];
        end
    end

endmodule

// File: tb/tb_window_avg.sv
// Directed bench for window_avg: unsigned and signed DATA_W=8, DEPTH=4 instances.
module tb_window_avg;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_u, clr_u, en_s, clr_s;
    logic [7:0] x_u, x_s, y_u, y_s;
    logic [9:0] sum_u, sum_s;
    logic       v_u, v_s;

    always #5 clk = ~clk;

    window_avg #(.DATA_W(8), .DEPTH(4), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .en(en_u), .clr(clr_u), .x(x_u),
        .y(y_u), .sum(sum_u), .y_valid(v_u)
    );

    window_avg #(.DATA_W(8), .DEPTH(4), .SIGNED(1)) s_dut (
        .clk(clk), .rst(rst), .en(en_s), .clr(clr_s), .x(x_s),
        .y(y_s), .sum(sum_s), .y_valid(v_s)
    );

    typedef struct {
        bit en;
        bit clr;
        int x;
        bit v;
        int s;
        int y;
    } vec_t;

    vec_t tu[$];
    vec_t ts[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input bit en, input bit clr, input int x,
                                input bit v, input int s, input int y);
        vec_t r;
        r.en = en; r.clr = clr; r.x = x; r.v = v; r.s = s; r.y = y;
        return r;
    endfunction

    // Expected average: truncated value t, or rounded value r when rounding is built in.
    function automatic int yr(input int t, input int r);
`ifdef WINDOW_AVG_ROUND_EN
        return r;
`else
        return t;
`endif
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(input bit sgn, input vec_t v, input string nm);
        @(negedge clk);
        if (!sgn) begin
            en_u = v.en; clr_u = v.clr; x_u = 8'(v.x);
        end else begin
            en_s = v.en; clr_s = v.clr; x_s = 8'(v.x);
        end
        @(posedge clk);
        #1;
        if (!sgn) begin
            check({nm, " valid"}, int'(v_u), int'(v.v));
            check({nm, " sum"}, int'(sum_u), v.s);
            check({nm, " y"}, int'(y_u), v.y);
        end else begin
            check({nm, " valid"}, int'(v_s), int'(v.v));
            check({nm, " sum"}, int'($signed(sum_s)), v.s);
            check({nm, " y"}, int'($signed(y_s)), v.y);
        end
    endtask

    initial begin
        // Fill from reset, wrap with 8, saturate the window with 255s.
        tu.push_back(mk(1, 0, 1,   0, 1,    yr(0, 0)));
        tu.push_back(mk(1, 0, 2,   0, 3,    yr(0, 1)));
        tu.push_back(mk(1, 0, 3,   0, 6,    yr(1, 2)));
        tu.push_back(mk(1, 0, 4,   1, 10,   yr(2, 3)));
        tu.push_back(mk(1, 0, 8,   1, 17,   yr(4, 4)));
        tu.push_back(mk(1, 0, 255, 1, 270,  yr(67, 68)));
        tu.push_back(mk(1, 0, 255, 1, 522,  yr(130, 131)));
        tu.push_back(mk(1, 0, 255, 1, 773,  yr(193, 193)));
        for (int i = 0; i < 5; i++) tu.push_back(mk(1, 0, 255, 1, 1020, yr(255, 255)));
        // Alternating en: outputs only move on enabled edges.
        tu.push_back(mk(1, 0, 5,   1, 770,  yr(192, 193)));
        tu.push_back(mk(0, 0, 77,  1, 770,  yr(192, 193)));
        tu.push_back(mk(1, 0, 7,   1, 522,  yr(130, 131)));
        tu.push_back(mk(0, 0, 77,  1, 522,  yr(130, 131)));
        tu.push_back(mk(1, 0, 9,   1, 276,  yr(69, 69)));
        tu.push_back(mk(0, 0, 77,  1, 276,  yr(69, 69)));
        tu.push_back(mk(1, 0, 11,  1, 32,   yr(8, 8)));
        tu.push_back(mk(0, 0, 77,  1, 32,   yr(8, 8)));
        // clr wins over en; 99 must not enter the window.
        tu.push_back(mk(1, 1, 99,  0, 0,    0));
        tu.push_back(mk(1, 0, 6,   0, 6,    yr(1, 2)));
        tu.push_back(mk(1, 0, 6,   0, 12,   yr(3, 3)));
        tu.push_back(mk(1, 0, 6,   0, 18,   yr(4, 5)));
        tu.push_back(mk(1, 0, 6,   1, 24,   yr(6, 6)));
        tu.push_back(mk(1, 0, 1,   1, 19,   yr(4, 5)));
        tu.push_back(mk(1, 0, 2,   1, 15,   yr(3, 4)));
        tu.push_back(mk(1, 0, 3,   1, 12,   yr(3, 3)));

        ts.push_back(mk(1, 0, -4,   0, -4,   yr(-1, -1)));
        ts.push_back(mk(1, 0, -4,   0, -8,   yr(-2, -2)));
        ts.push_back(mk(1, 0, -4,   0, -12,  yr(-3, -3)));
        ts.push_back(mk(1, 0, -3,   1, -15,  yr(-4, -4)));
        ts.push_back(mk(1, 0, 127,  1, 116,  yr(29, 29)));
        ts.push_back(mk(1, 0, 127,  1, 247,  yr(61, 62)));
        ts.push_back(mk(1, 0, 127,  1, 378,  yr(94, 95)));
        ts.push_back(mk(1, 0, 127,  1, 508,  yr(127, 127)));
        ts.push_back(mk(1, 0, -128, 1, 253,  yr(63, 63)));
        ts.push_back(mk(1, 0, -128, 1, -2,   yr(-1, 0)));
        ts.push_back(mk(1, 0, -128, 1, -257, yr(-65, -64)));
        ts.push_back(mk(1, 0, -128, 1, -512, yr(-128, -128)));

        rst = 1'b1;
        en_u = 0; clr_u = 0; x_u = '0;
        en_s = 0; clr_s = 0; x_s = '0;
        #12;
        check("reset u sum", int'(sum_u), 0);
        check("reset u y", int'(y_u), 0);
        check("reset u valid", int'(v_u), 0);
        check("reset s sum", int'(sum_s), 0);
        check("reset s y", int'(y_s), 0);
        check("reset s valid", int'(v_s), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tu.size(); i++) apply(1'b0, tu[i], $sformatf("u[%0d]", i));

        // Asynchronous reset mid-cycle while streaming.
        @(negedge clk);
        en_u = 1; clr_u = 0; x_u = 8'd50;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async rst sum", int'(sum_u), 0);
        check("async rst y", int'(y_u), 0);
        check("async rst valid", int'(v_u), 0);
        @(negedge clk);
        rst = 1'b0;
        en_u = 0;
        apply(1'b0, mk(1, 0, 10, 0, 10, yr(2, 3)),   "post-rst 1");
        apply(1'b0, mk(1, 0, 10, 0, 20, yr(5, 5)),   "post-rst 2");
        apply(1'b0, mk(1, 0, 10, 0, 30, yr(7, 8)),   "post-rst 3");
        apply(1'b0, mk(1, 0, 10, 1, 40, yr(10, 10)), "post-rst 4");
        @(negedge clk);
        en_u = 0;

        for (int i = 0; i < ts.size(); i++) apply(1'b1, ts[i], $sformatf("s[%0d]", i));
        @(negedge clk);
        en_s = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/window_avg.md
Name: window_avg

Overview:
- Parametrised sliding-window averager: successor to the single-channel 32-bit en/x/y datapath block.
- Each enabled cycle it accepts one sample `x` and keeps a running sum over the last DEPTH samples in a circular buffer.
- It outputs the full-precision sum and the window average with a valid flag.
- Sits between a sample source and downstream filtering/decision logic in the datapath.

Parameters:
- DATA_W, 32, sample and average width in bits.
- DEPTH, 8, window length in samples; power of two, 2..256.
- SIGNED, 0, 1 = samples two's complement (sign-extended sum, arithmetic shift); 0 = unsigned.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  sample strobe; `x` is accepted on a rising edge where en=1.
- clr  in  1  synchronous clear of window, sum and fill count; priority over en.
- x  in  DATA_W  input sample.
- y  out  DATA_W  window average = sum >> log2(DEPTH) (arithmetic if SIGNED).
- sum  out  DATA_W+log2(DEPTH)  full-precision running sum, never overflows.
- y_valid  out  1  high once DEPTH samples have been accepted since reset/clr.

Behaviour:
- Definitions:
  - SW = DATA_W + AW, where AW = log2(DEPTH).
  - Buffer: DEPTH x DATA_W registers.
  - Write pointer `wp`: AW bits.
  - Fill counter `cnt`: 0..DEPTH, saturating.
- Reset (async, rst=1): y=0, sum=0, y_valid=0, wp=0, cnt=0, all buffer entries=0. Outputs are held until rst deasserts.
- Edge with clr=1:
  - Same state as reset, applied synchronously.
  - en on that edge is ignored; `x` is discarded.
- Edge with en=1, clr=0:
  - `old` = buf[wp] (value being evicted; 0 while not yet written, guaranteed by zeroed buffer).
  - buf[wp] <= x.
  - wp <= wp+1, wrapping DEPTH-1 -> 0.
  - sum <= sum + ext(x) - ext(old); ext = sign- or zero-extend to SW per SIGNED.
  - cnt <= min(cnt+1, DEPTH).
  - y_valid <= (cnt+1 >= DEPTH).
  - y <= new sum >> AW.
- Latency: sum/y/y_valid reflect sample k in the cycle after the edge accepting it (1-cycle, registered). No combinational path from x to outputs.
- Edge with en=0, clr=0: all state holds; y, sum and y_valid are unchanged.
- Warm-up (cnt<DEPTH): y = partial sum >> AW; y_valid=0. Consumers ignore y until y_valid.
- Wrap-around: after DEPTH samples, each new sample evicts the oldest. `sum` stays exact indefinitely, with no drift.
- Width: SW bits hold DEPTH*max|x| exactly, so no saturation logic is needed.
- y is the low DATA_W bits of the shifted sum, which always fits.

Optional Feature:
- Macro: WINDOW_AVG_ROUND_EN.
- Defined: y <= (sum_next + 2^(AW-1)) >> AW, i.e. round half up; arithmetic shift when SIGNED. The adder is SW+1 bits, and the result is clamped to the DATA_W max (unsigned or signed) if rounding would exceed it.
- Undefined: y is truncated (floor) as above.
- `sum` and `y_valid` are unaffected either way.

Decomposition:
- Shared package `window_avg_pkg`:
  - Constant function clog2.
  - Localparams AW and SW derived from DEPTH/DATA_W.
  - Ext/shift helper functions parametrised by SIGNED.
- Sub-module `window_buf`:
  - Circular register buffer with write pointer.
  - Ports: clk, rst, clr, we, din, dout_old.
  - dout_old is the combinational read of buf[wp].
- The top holds the sum, fill counter, output registers and rounding.

Test Plan:
- DATA_W=8, DEPTH=4, unsigned; after reset feed 1,2,3,4 with en=1 -> y_valid 0,0,0,1; sum=1,3,6,10; y=2 (ROUND_EN: y=3).
- Same config, then feed 8 -> sum=2+3+4+8=17, y=4 (ROUND_EN: 4); then eight samples of 255 -> sum=1020, y=255, no overflow.
- Alternate en=1/0 with samples 5,7,9,11 -> outputs update only on en edges; final sum=32, y=8, y_valid=1; outputs stable on en=0 cycles.
- Assert clr with en=1 and x=99 after a full window -> next cycle sum=0, y=0, y_valid=0; then 4 samples of 6 -> y_valid rises on the 4th, y=6.
- Assert rst asynchronously mid-cycle during streaming -> y, sum, y_valid go to 0 immediately without waiting for clk; after release, a fresh window of 4 is required before y_valid.
- SIGNED=1, DATA_W=8, DEPTH=4: feed -4,-4,-4,-3 -> sum=-15, y=-4 (0xFC); feed 127 x4 -> y=127; feed -128 x4 -> y=-128.
